// File: rtl/usr_shift_sequencer.sv
// ---------------------------------------------------------------------------
// usr_shift_sequencer
//
// Purpose:
//   Command sequencer placed directly upstream of universal_shift_reg. It
//   accepts a single {data, direction, count, fill} command through a
//   valid/ready handshake. It then runs the whole job without further
//   control: one parallel load, followed by 'count' shift cycles. Finally it
//   samples the register's parallel output and returns it on result_o,
//   together with a one-cycle done_o pulse.
//
// Parameters:
//   WIDTH  data width, equal to the universal_shift_reg width
//   CNT_W  width of the shift count (0 .. 2**CNT_W-1 shifts)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid_i  command present
//   cmd_ready_o  sequencer can accept a command (only while IDLE)
//   cmd_data_i   parallel load value
//   cmd_dir_i    0 = shift right (srin), 1 = shift left (slin)
//   cmd_count_i  number of shift cycles after the load
//   cmd_fill_i   serial bit shifted in on every shift cycle
//   abort_i      synchronous abort of a running command
//   pout_i       parallel output of universal_shift_reg
//   sel_o        register mode: 00 hold, 01 right, 10 left, 11 load
//   pin_o        parallel load data (last accepted cmd_data_i)
//   srin_o       serial input for right shifts
//   slin_o       serial input for left shifts
//   busy_o       high while a command is in progress
//   done_o       one-cycle pulse, result_o valid
//   result_o     register contents captured at the end of a command
// ---------------------------------------------------------------------------
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic             cmd_dir_i,
    input  logic [CNT_W-1:0] cmd_count_i,
    input  logic             cmd_fill_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] pout_i,
    output logic [1:0]       sel_o,
    output logic [WIDTH-1:0] pin_o,
    output logic             srin_o,
    output logic             slin_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic             dir_q;
    logic             fill_q;
    logic             accept;

    assign accept = cmd_valid_i & cmd_ready_o;

    // State register. The sequencer always restarts from IDLE, and any
    // partially completed job is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort is honoured in every busy state but has no
    // meaning in IDLE. As a result, a command that arrives together with an
    // abort is still accepted. The shift counter starts at the requested
    // count, so the transition out of SHIFT happens on the edge where it
    // reads 1. That edge is the count-th shift edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else if (counter == '0) begin
                    next_state = DONE;
                end else begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else if (counter == CNT_W'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Moore output decode. Register control and the handshake depend only on
    // the state and the latched command fields. The fill bit is routed to the
    // serial input on the side matching the shift direction, and the other
    // serial input is held at 0.
    always_comb begin
        sel_o       = 2'b00;
        srin_o      = 1'b0;
        slin_o      = 1'b0;
        busy_o      = 1'b0;
        cmd_ready_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
            end
            LOAD: begin
                sel_o  = 2'b11;
                busy_o = 1'b1;
            end
            SHIFT: begin
                busy_o = 1'b1;
                if (dir_q) begin
                    sel_o  = 2'b10;
                    slin_o = fill_q;
                end else begin
                    sel_o  = 2'b01;
                    srin_o = fill_q;
                end
            end
            DONE: begin
                busy_o = 1'b1;
            end
            default: begin
                cmd_ready_o = 1'b1;
            end
        endcase
    end

    // Command capture. Fields are sampled only on the acceptance edge, so
    // upstream logic may change them freely while a job is running. pin_o
    // keeps the last accepted data until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_o  <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else if (accept) begin
            pin_o  <= cmd_data_i;
            dir_q  <= cmd_dir_i;
            fill_q <= cmd_fill_i;
        end
    end

    // Shift counter. It is loaded with the requested count on acceptance and
    // decremented on every SHIFT edge. It also serves as the zero-count test
    // in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (accept) begin
            counter <= cmd_count_i;
        end else if (state == SHIFT) begin
            counter <= counter - CNT_W'(1);
        end
    end

    // Result capture and done pulse. The register has finished its last
    // shift by the time the FSM sits in DONE, so pout_i is sampled on the
    // edge that leaves DONE. An abort in DONE suppresses the capture, and
    // the previous result is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if ((state == DONE) && !abort_i) begin
                result_o <= pout_i;
                done_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usr_shift_sequencer
//
// Purpose:
//   Self-checking bench for usr_shift_sequencer. A small behavioural stand-in
//   for universal_shift_reg is driven by the sequencer's outputs. Each job's
//   final value is predicted arithmetically from the command fields alone.
//   Directed jobs cover the documented scenarios, and randomized jobs fill
//   in the rest.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             tb_clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic             abort;
    logic [WIDTH-1:0] usr_q;
    logic [1:0]       sel;
    logic [WIDTH-1:0] pin;
    logic             srin;
    logic             slin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int               tests_run;
    int               tests_failed;
    logic [WIDTH-1:0] last_result;

    usr_shift_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (tb_clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_data_i  (cmd_data),
        .cmd_dir_i   (cmd_dir),
        .cmd_count_i (cmd_count),
        .cmd_fill_i  (cmd_fill),
        .abort_i     (abort),
        .pout_i      (usr_q),
        .sel_o       (sel),
        .pin_o       (pin),
        .srin_o      (srin),
        .slin_o      (slin),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    // 20 ns clock.
    initial begin
        tb_clk = 1'b0;
        forever #10 tb_clk = ~tb_clk;
    end

    // Behavioural stand-in for the downstream universal_shift_reg.
    always_ff @(posedge tb_clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_q <= '0;
        end else begin
            case (sel)
                2'b11:   usr_q <= pin;
                2'b01:   usr_q <= {srin, usr_q[WIDTH-1:1]};
                2'b10:   usr_q <= {usr_q[WIDTH-2:0], slin};
                default: usr_q <= usr_q;
            endcase
        end
    end

    // Bail out with a failure if the run ever stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected register value after loading d and shifting c times in
    // direction dir with fill bit f. Counts of WIDTH or more leave nothing
    // but fill bits in the register.
    function automatic logic [WIDTH-1:0] expected_result(input logic [WIDTH-1:0] d,
                                                         input logic dir,
                                                         input int c,
                                                         input logic f);
        int unsigned v;
        int unsigned ones;
        int unsigned full;
        full = (1 << WIDTH) - 1;
        if (c >= WIDTH) begin
            v = f ? full : 0;
        end else begin
            ones = (1 << c) - 1;
            if (!dir) begin
                v = int'(d) >> c;
                if (f) v = v | (ones << (WIDTH - c));
            end else begin
                v = (int'(d) << c) & full;
                if (f) v = v | ones;
            end
        end
        return WIDTH'(v);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Present a command and raise valid; acceptance happens on the next edge
    // where ready is high.
    task automatic apply_stimulus(input logic [WIDTH-1:0] d, input logic dir,
                                  input logic [CNT_W-1:0] c, input logic f);
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_count = c;
        cmd_fill  = f;
        cmd_valid = 1'b1;
    endtask

    // Scribble over the command fields after acceptance; the job in flight
    // must not notice.
    task automatic scramble_fields();
        cmd_data  = WIDTH'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_count = CNT_W'($urandom);
        cmd_fill  = 1'($urandom);
    endtask

    // Follow an accepted job cycle by cycle, starting #1 into the LOAD cycle.
    // Returns #1 into the cycle in which done should be high.
    task automatic track_job(input logic [WIDTH-1:0] d, input logic dir,
                             input logic [CNT_W-1:0] c, input logic f);
        logic [WIDTH-1:0] exp;
        exp = expected_result(d, dir, int'(c), f);
        check_output("load_sel", 32'(sel), 32'd3);
        check_output("load_busy", 32'(busy), 32'd1);
        check_output("load_ready", 32'(cmd_ready), 32'd0);
        check_output("load_pin", 32'(pin), 32'(d));
        for (int i = 0; i < int'(c); i++) begin
            @(posedge tb_clk); #1;
            check_output("shift_sel", 32'(sel), dir ? 32'd2 : 32'd1);
            check_output("shift_srin", 32'(srin), dir ? 32'd0 : 32'(f));
            check_output("shift_slin", 32'(slin), dir ? 32'(f) : 32'd0);
            check_output("shift_ready", 32'(cmd_ready), 32'd0);
            check_output("shift_done", 32'(done), 32'd0);
        end
        @(posedge tb_clk); #1;
        check_output("done_state_sel", 32'(sel), 32'd0);
        check_output("done_state_serial", 32'({srin, slin}), 32'd0);
        check_output("done_state_busy", 32'(busy), 32'd1);
        check_output("done_state_pulse", 32'(done), 32'd0);
        @(posedge tb_clk); #1;
        check_output("done_pulse", 32'(done), 32'd1);
        check_output("result", 32'(result), 32'(exp));
        check_output("idle_ready", 32'(cmd_ready), 32'd1);
        check_output("idle_busy", 32'(busy), 32'd0);
        last_result = exp;
    endtask

    // A complete, isolated job: accept, track, then confirm done drops.
    task automatic run_job(input logic [WIDTH-1:0] d, input logic dir,
                           input logic [CNT_W-1:0] c, input logic f);
        apply_stimulus(d, dir, c, f);
        @(posedge tb_clk); #1;
        cmd_valid = 1'b0;
        scramble_fields();
        track_job(d, dir, c, f);
        @(posedge tb_clk); #1;
        check_output("done_single_cycle", 32'(done), 32'd0);
        check_output("idle_sel", 32'(sel), 32'd0);
    endtask

    // Check every output against its reset value.
    task automatic check_reset_values(input string tag);
        check_output({tag, "_sel"}, 32'(sel), 32'd0);
        check_output({tag, "_pin"}, 32'(pin), 32'd0);
        check_output({tag, "_serial"}, 32'({srin, slin}), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_result"}, 32'(result), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_result  = '0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_data     = '0;
        cmd_dir      = 1'b0;
        cmd_count    = '0;
        cmd_fill     = 1'b0;
        abort        = 1'b0;

        #5;
        check_reset_values("reset");
        #30;
        rst_n = 1'b1;
        @(posedge tb_clk); #1;

        // Test 1: right shift by 2 with fill 1.
        run_job(4'b1101, 1'b0, 3'd2, 1'b1);
        check_output("t1_value", 32'(result), 32'b1111);

        // Test 2: left shift by 1 with fill 0.
        run_job(4'b1101, 1'b1, 3'd1, 1'b0);
        check_output("t2_value", 32'(result), 32'b1010);

        // Test 3: zero count, with abort raised during acceptance. The abort
        // has no effect in IDLE, so the command is still accepted.
        apply_stimulus(4'b0110, 1'b0, 3'd0, 1'b1);
        abort = 1'b1;
        @(posedge tb_clk); #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        scramble_fields();
        track_job(4'b0110, 1'b0, 3'd0, 1'b1);
        check_output("t3_value", 32'(result), 32'b0110);
        @(posedge tb_clk); #1;

        // Test 4: a second command is held valid through the whole first job.
        // It is accepted on the edge that ends the done cycle.
        apply_stimulus(4'b1001, 1'b0, 3'd1, 1'b0);
        @(posedge tb_clk); #1;
        apply_stimulus(4'b0011, 1'b1, 3'd2, 1'b1);
        track_job(4'b1001, 1'b0, 3'd1, 1'b0);
        @(posedge tb_clk); #1;
        cmd_valid = 1'b0;
        check_output("t4_b2b_done_drop", 32'(done), 32'd0);
        track_job(4'b0011, 1'b1, 3'd2, 1'b1);
        @(posedge tb_clk); #1;

        // Test 5: abort in the second SHIFT cycle of a count-5 job.
        apply_stimulus(4'b0101, 1'b0, 3'd5, 1'b0);
        @(posedge tb_clk); #1;
        cmd_valid = 1'b0;
        @(posedge tb_clk); #1;
        @(posedge tb_clk); #1;
        check_output("t5_in_shift", 32'(sel), 32'd1);
        abort = 1'b1;
        @(posedge tb_clk); #1;
        abort = 1'b0;
        check_output("t5_abort_sel", 32'(sel), 32'd0);
        check_output("t5_abort_busy", 32'(busy), 32'd0);
        check_output("t5_abort_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_output("t5_no_done", 32'(done), 32'd0);
            check_output("t5_result_kept", 32'(result), 32'(last_result));
            @(posedge tb_clk); #1;
        end

        // Test 6: reset pulled mid-SHIFT, then test 1 again.
        apply_stimulus(4'b1110, 1'b1, 3'd5, 1'b1);
        @(posedge tb_clk); #1;
        cmd_valid = 1'b0;
        @(posedge tb_clk); #1;
        @(posedge tb_clk); #1;
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_midreset");
        @(negedge tb_clk);
        rst_n = 1'b1;
        @(posedge tb_clk); #1;
        run_job(4'b1101, 1'b0, 3'd2, 1'b1);
        check_output("t6_rerun_value", 32'(result), 32'b1111);

        // Randomized jobs over the full count range, both directions.
        for (int n = 0; n < 40; n++) begin
            run_job(WIDTH'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
